// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared defaults and FSM encoding for the fifo write arbiter
package fifo_wr_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just after the last winner
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] k;
  logic found;
  always_comb begin
    gnt_o = '0;
    gnt_idx_o = '0;
    found = 1'b0;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last_i) + i) % N);
      if (!found && req_i[k]) begin
        found = 1'b1;
        gnt_o[k] = 1'b1;
        gnt_idx_o = k;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one fifo write port, one write per 3 cycles
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       arb_en_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       fifo_full_i,
  output logic                       w_valid_o,
  output logic [WIDTH-1:0]           data_in_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           wr_count_o
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] last_q, grant_id_q, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic pick_any, grant;
  logic w_valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  rr_picker #(.N(NUM_REQ)) u_pick (
    .req_i    (req_valid_i),
    .last_i   (last_q),
    .gnt_o    (pick_gnt),
    .gnt_idx_o(pick_idx),
    .any_o    (pick_any)
  );
  // fifo_full is only trusted in IDLE; the GAP cycle gives it time to settle
  assign grant = reset_ni && state_q == ST_IDLE && arb_en_i && !fifo_full_i && pick_any;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (grant ? ST_WRITE : ST_IDLE) :
              (state_q == ST_WRITE) ? ST_GAP : ST_IDLE;
  end
  always_comb begin
    req_ready_o = grant ? pick_gnt : '0;
    busy_o = state_q != ST_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      w_valid_q <= 1'b0;
      data_q <= '0;
      grant_id_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      w_valid_q <= state_d == ST_WRITE;
      if (grant) begin
        data_q <= req_data_i[pick_idx*WIDTH +: WIDTH];
        last_q <= pick_idx;
        grant_id_q <= pick_idx;
      end
      if (state_q == ST_WRITE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign w_valid_o = w_valid_q;
  assign data_in_o = data_q;
  assign grant_id_o = grant_id_q;
  assign wr_count_o = cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a DEPTH=3 fifo model in front of the arbiter
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int CW = 16;
  localparam int DEPTH = 3;
  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic arb_en = 1'b0;
  logic fifo_full = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic w_valid, busy;
  logic [W-1:0] data_in;
  logic [1:0] grant_id;
  logic [CW-1:0] wr_count;
  int tests_run = 0;
  int failed = 0;
  int left[N];
  int seq[N];
  int exp_seq[N];
  logic [W-1:0] base[N];
  exp_t exp_q[$];
  logic [W-1:0] fifo_m[$];
  int exp_count = 0;
  bit rd_en = 1'b0;
  bit chk_period = 1'b0;
  int cyc = 0;
  int last_wr = -1;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .arb_en_i   (arb_en),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .fifo_full_i(fifo_full),
    .w_valid_o  (w_valid),
    .data_in_o  (data_in),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .wr_count_o (wr_count)
  );
  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = left[i] > 0;
      req_data[i*W +: W] = base[i] + W'(seq[i]) + 1;
    end
  endfunction
  function automatic void push_exp(int i);
    exp_t e;
    e.id = 2'(i);
    e.data = base[i] + W'(exp_seq[i]) + 1;
    exp_q.push_back(e);
    exp_seq[i]++;
    exp_count++;
  endfunction
  task automatic tick();
    logic [N-1:0] hs;
    logic wv;
    exp_t e;
    @(negedge clk);
    hs = req_valid & req_ready;
    wv = w_valid === 1'b1;
    tests_run++;
    if (((req_ready & ~req_valid) !== '0) || $countones(req_ready) > 1 || (!reset_n && req_ready !== '0)) begin
      failed++;
      $display("FAIL grant_legal: req_ready=%b req_valid=%b reset_n=%b, required one-hot subset of req_valid and 0 in reset", req_ready, req_valid, reset_n);
    end
    if (wv && reset_n) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: got id=%0d data=%h, required no write", grant_id, data_in);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, data_in} !== {e.id, e.data}) begin
          failed++;
          $display("FAIL write_order: got id=%0d data=%h, required id=%0d data=%h", grant_id, data_in, e.id, e.data);
        end
      end
      if (chk_period && last_wr >= 0) begin
        tests_run++;
        if (cyc - last_wr != 3) begin
          failed++;
          $display("FAIL write_period: got %0d cycles, required 3", cyc - last_wr);
        end
      end
      last_wr = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
      fifo_m.delete();
      exp_count = 0;
    end else begin
      if (rd_en && fifo_m.size() > 0) void'(fifo_m.pop_front());
      if (wv) begin
        tests_run++;
        if (fifo_m.size() >= DEPTH) begin
          failed++;
          $display("FAIL fifo_overflow: got write with %0d words stored, required below %0d", fifo_m.size(), DEPTH);
        end else fifo_m.push_back(data_in);
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          seq[i]++;
          left[i]--;
        end
      end
    end
    fifo_full = fifo_m.size() == DEPTH;
    drive();
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic drain(string nm, int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drain: got %0d writes outstanding after %0d cycles, required 0", nm, exp_q.size(), max);
      exp_q.delete();
    end
    run(4);
  endtask
  task automatic wait_wv(string nm);
    int n = 0;
    while (w_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    tests_run++;
    if (w_valid !== 1'b1) begin
      failed++;
      $display("FAIL %s_timeout: got w_valid=%b after 30 cycles, required 1", nm, w_valid);
    end
  endtask
  task automatic check_count(string nm);
    tests_run++;
    if (wr_count !== CW'(exp_count)) begin
      failed++;
      $display("FAIL %s_wr_count: got %0d, required %0d", nm, wr_count, exp_count);
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    arb_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < N; i++) left[i] = 1;
    drive();
    repeat (2) begin
      tick();
      tests_run++;
      if ({req_ready, w_valid, wr_count} !== '0) begin
        failed++;
        $display("FAIL reset_outputs: got ready=%b w_valid=%b wr_count=%0d, required all 0", req_ready, w_valid, wr_count);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) push_exp(i);
    drain("reset", 40);
    check_count("reset");
  endtask
  task automatic test_round_robin();
    chk_period = 1'b1;
    last_wr = -1;
    for (int i = 0; i < N; i++) left[i] = 6;
    drive();
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < N; i++) push_exp(i);
    drain("round_robin", 120);
    chk_period = 1'b0;
    check_count("round_robin");
  endtask
  task automatic test_single();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    base[2] = 32'hA5A5_0000;
    seq[2] = 0;
    exp_seq[2] = 0;
    left[2] = 5;
    drive();
    chk_period = 1'b1;
    last_wr = -1;
    repeat (5) push_exp(2);
    drain("single", 40);
    chk_period = 1'b0;
    tests_run++;
    if (wr_count !== 16'd5) begin
      failed++;
      $display("FAIL single_wr_count: got %0d, required 5", wr_count);
    end
  endtask
  task automatic test_full();
    rd_en = 1'b0;
    left[0] = 5;
    left[1] = 5;
    drive();
    push_exp(0);
    push_exp(1);
    push_exp(0);
    drain("full_fill", 30);
    repeat (6) begin
      tick();
      tests_run++;
      if (req_ready !== '0 || w_valid !== 1'b0) begin
        failed++;
        $display("FAIL full_stall: got ready=%b w_valid=%b, required 0 and 0 while full", req_ready, w_valid);
      end
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    push_exp(1);
    drain("full_one", 20);
    rd_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push_exp(0);
      push_exp(1);
    end
    drain("full_rest", 60);
  endtask
  task automatic test_arb_en();
    left[2] = 2;
    left[3] = 2;
    drive();
    push_exp(2);
    wait_wv("arb_en");
    arb_en = 1'b0;
    drain("arb_en_inflight", 10);
    tests_run++;
    if (busy !== 1'b0 || req_ready !== '0 || req_valid === '0) begin
      failed++;
      $display("FAIL arb_en_hold: got busy=%b ready=%b valid=%b, required busy=0 ready=0 with requests pending", busy, req_ready, req_valid);
    end
    arb_en = 1'b1;
    push_exp(3);
    push_exp(2);
    push_exp(3);
    drain("arb_en_resume", 30);
  endtask
  task automatic test_reset_mid();
    left[0] = 1;
    drive();
    push_exp(0);
    wait_wv("gap");
    tick();
    tests_run++;
    if (busy !== 1'b1 || w_valid !== 1'b0) begin
      failed++;
      $display("FAIL gap_state: got busy=%b w_valid=%b, required busy=1 w_valid=0", busy, w_valid);
    end
    reset_n = 1'b0;
    tick();
    tests_run++;
    if (w_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL gap_reset: got w_valid=%b busy=%b, required 0 and 0", w_valid, busy);
    end
    reset_n = 1'b1;
    left[0] = 1;
    left[3] = 1;
    drive();
    wait_wv("write");
    tests_run++;
    if (grant_id !== 2'd0) begin
      failed++;
      $display("FAIL last_grant_reset: got grant_id=%0d, required 0", grant_id);
    end
    exp_seq[0]++;
    reset_n = 1'b0;
    tick();
    tests_run++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || wr_count !== '0) begin
      failed++;
      $display("FAIL write_reset: got w_valid=%b busy=%b wr_count=%0d, required 0 0 0", w_valid, busy, wr_count);
    end
    reset_n = 1'b1;
    push_exp(3);
    drain("write_reset", 20);
    check_count("write_reset");
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      seq[i] = 0;
      exp_seq[i] = 0;
      base[i] = W'(i + 1) << 28;
    end
    drive();
    test_reset();
    test_round_robin();
    test_single();
    test_full();
    test_arb_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
